sobel_3x3: RTL
==============

SOBEL_3X3 -- requirements
Module: sobel_3x3

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, the pixel width.
REQ-002 SHALL have parameter MAX_DATA_LENGTH, default 1024, the maximum number of pixels per line; the column counter is $clog2(MAX_DATA_LENGTH) bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port vsync_i, input, 1 bit: frame sync, active-high.
REQ-006 SHALL have port de_i, input, 1 bit: three-row pixel column valid (line-buffer de_o).
REQ-007 SHALL have port data0_i, input, DATA_WIDTH: oldest row (row 0).
REQ-008 SHALL have port data1_i, input, DATA_WIDTH: middle row (row 1).
REQ-009 SHALL have port data2_i, input, DATA_WIDTH: newest row (row 2).
REQ-010 SHALL have port vsync_o, output, 1 bit: vsync_i delayed by LATENCY.
REQ-011 SHALL have port de_o, output, 1 bit: de_i delayed by LATENCY.
REQ-012 SHALL have port data_o, output, DATA_WIDTH: saturated Sobel magnitude.

Function
REQ-013 SHALL keep a 3x3 window p[r][c], r = 0..2 (row), c = 0..2 (c = 2 is the newest column), shifting one column per cycle only when de_i = 1.
REQ-014 SHALL hold the window unchanged when de_i = 0.
REQ-015 SHALL keep a per-line column counter col that increments on each de_i = 1 cycle, clears to 0 on any de_i = 0 cycle, and clears when vsync_i = 1.
REQ-016 SHALL compute Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20), signed, DATA_WIDTH+4 bits, with no overflow possible.
REQ-017 SHALL compute Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02), signed, DATA_WIDTH+4 bits.
REQ-018 SHALL compute mag = |Gx| + |Gy|, unsigned, and saturate it to 2^DATA_WIDTH - 1.
REQ-019 SHALL pipeline the datapath in three stages: S1 window and column flag, S2 Gx/Gy, S3 abs, sum and saturate.
REQ-020 SHALL have LATENCY = 3: input column n at cycle t produces output at cycle t+3.
REQ-021 SHALL make the output for input column n >= 2 the Sobel result centred on column n-1.
REQ-022 SHALL force data_o = 0 for input columns n = 0 and n = 1 (left border), so the output pixel count per line equals the input pixel count.
REQ-023 SHALL drive data_o = 0 whenever de_o = 0.
REQ-024 SHALL produce no extra output after de_i falls; the last column is not flushed.
REQ-025 SHALL forward vsync_i and de_i through the same 3-stage delay; de_o is never asserted without a corresponding de_i.
REQ-026 SHALL, when vsync_i is asserted mid-line, clear col; pixels already in flight still emerge with their de_o.
REQ-027 SHALL, when vsync_i and de_i are high in the same cycle, apply the col clear first, so that the pixel counts as column 0.
REQ-028 SHALL support back-to-back lines separated by a single de_i = 0 cycle.

Reset
REQ-029 SHALL, while rst_n = 0, asynchronously clear vsync_o, de_o, data_o, all pipeline valid/data registers, the window and col to 0.
REQ-030 SHALL, after rst_n deasserts mid-line, treat the first de_i = 1 cycle as column 0.

Structure
REQ-031 SHALL place LATENCY = 3 and the kernel coefficient widths in a shared package sobel_pkg.
REQ-032 SHALL implement the S2/S3 arithmetic as one sub-module, sobel_kernel: nine pixels in, magnitude out, pipelined, reset-free data path.
REQ-033 SHALL keep the window, column counter and sync delay in the sobel_3x3 top level.

Verification (DATA_WIDTH = 10)
REQ-034 SHALL cover a flat field: all rows = 100 for a 640-pixel line -> 640 de_o cycles, 3 cycles after de_i, with data_o = 0 throughout.
REQ-035 SHALL cover a vertical edge: all rows 0 for columns 0..3 and 100 from column 4 on -> outputs for input n = 4 and n = 5 are 400; all others 0.
REQ-036 SHALL cover a horizontal edge: data0 = data1 = 0, data2 = 50 -> data_o = 200 for n >= 2, and 0 for n = 0 and n = 1.
REQ-037 SHALL cover saturation: rows 0 for columns 0..3 and 1023 from column 4 on -> Gx = 4092 clipped to data_o = 1023 at n = 4 and n = 5.
REQ-038 SHALL cover reset mid-line: rst_n low at column 300 -> outputs 0 immediately; the next line restarts with n = 0 and n = 1 forced to 0.
REQ-039 SHALL cover vsync mid-line: vsync_o follows 3 cycles later, in-flight pixels are delivered, and col restarts at 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants for the 3x3 Sobel edge filter: pipeline depth and
// growth of the kernel arithmetic relative to the pixel width.
package sobel_pkg;
  localparam int LATENCY   = 3;
  // 1-2-1 weighted sum grows by x4; the signed gradient adds sign and headroom
  localparam int SUM_GROW  = 2;
  localparam int GRAD_GROW = 4;
endpackage

// File: rtl/sobel_kernel.sv
// Sobel arithmetic: registers Gx/Gy from the nine window pixels, then
// forms the saturated |Gx| + |Gy| magnitude combinationally from those registers.
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] p00_i,
  input  logic [DATA_WIDTH-1:0] p01_i,
  input  logic [DATA_WIDTH-1:0] p02_i,
  input  logic [DATA_WIDTH-1:0] p10_i,
  input  logic [DATA_WIDTH-1:0] p11_i,
  input  logic [DATA_WIDTH-1:0] p12_i,
  input  logic [DATA_WIDTH-1:0] p20_i,
  input  logic [DATA_WIDTH-1:0] p21_i,
  input  logic [DATA_WIDTH-1:0] p22_i,
  output logic [DATA_WIDTH-1:0] mag_o
);
  localparam int SW = DATA_WIDTH + SUM_GROW;
  localparam int GW = DATA_WIDTH + GRAD_GROW;

  function automatic logic [SW-1:0] wsum(input logic [DATA_WIDTH-1:0] a,
                                         input logic [DATA_WIDTH-1:0] b,
                                         input logic [DATA_WIDTH-1:0] c);
    return SW'(a) + SW'({b, 1'b0}) + SW'(c);
  endfunction

  logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic        [GW-1:0] ax_s, ay_s;
  logic        [GW:0]   sum_s;

  // Gradient differences for the S2 registers
  always_comb begin
    gx_d = signed'(GW'(wsum(p02_i, p12_i, p22_i))) - signed'(GW'(wsum(p00_i, p10_i, p20_i)));
    gy_d = signed'(GW'(wsum(p20_i, p21_i, p22_i))) - signed'(GW'(wsum(p00_i, p01_i, p02_i)));
  end

  // S2 gradient registers; data path only, qualified by the caller's valid
  always_ff @(posedge clk) begin
    gx_q <= gx_d;
    gy_q <= gy_d;
  end

  // Absolute values, sum and clip to the pixel range
  always_comb begin
    ax_s  = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
    ay_s  = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
    sum_s = {1'b0, ax_s} + {1'b0, ay_s};
    if (sum_s[GW:DATA_WIDTH] != '0) begin
      mag_o = {DATA_WIDTH{1'b1}};
    end else begin
      mag_o = sum_s[DATA_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/sobel_3x3.sv
// 3x3 Sobel edge-magnitude filter on a three-row column stream: column
// window, per-line column counter, sync delay and border blanking.
module sobel_3x3
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH      = 10,
  parameter int MAX_DATA_LENGTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync_i,
  input  logic                  de_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic [DATA_WIDTH-1:0] data2_i,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  localparam int CW = $clog2(MAX_DATA_LENGTH);

  logic [2:0][2:0][DATA_WIDTH-1:0] win_d, win_q;
  logic [CW-1:0]                   col_d, col_q, col_eff_s;
  logic                            border_d;
  logic [LATENCY-2:0]              border_q;
  logic [LATENCY-1:0]              de_q, vs_q;
  logic [DATA_WIDTH-1:0]           data_d, data_q, mag_s;

  // Window shift and column count; vsync clears col before this pixel is counted
  always_comb begin
    win_d     = win_q;
    col_eff_s = vsync_i ? '0 : col_q;
    col_d     = '0;
    border_d  = 1'b0;
    if (de_i) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = data0_i;
      win_d[1][2] = data1_i;
      win_d[2][2] = data2_i;
      border_d    = (col_eff_s < CW'(2'd2));
      col_d       = (col_eff_s == {CW{1'b1}}) ? col_eff_s : col_eff_s + CW'(1'b1);
    end else begin
      col_d = '0;
    end
  end

  // Columns 0 and 1 lack a full left neighbourhood and are blanked
  always_comb begin
    if (de_q[LATENCY-2] && !border_q[LATENCY-2]) begin
      data_d = mag_s;
    end else begin
      data_d = '0;
    end
  end

  // S1 window/flags, sync delay line and S3 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q    <= '0;
      col_q    <= '0;
      border_q <= '0;
      de_q     <= '0;
      vs_q     <= '0;
      data_q   <= '0;
    end else begin
      win_q    <= win_d;
      col_q    <= col_d;
      border_q <= {border_q[LATENCY-3:0], border_d};
      de_q     <= {de_q[LATENCY-2:0], de_i};
      vs_q     <= {vs_q[LATENCY-2:0], vsync_i};
      data_q   <= data_d;
    end
  end

  sobel_kernel #(.DATA_WIDTH(DATA_WIDTH)) u_kernel (
    .clk   (clk),
    .p00_i (win_q[0][0]),
    .p01_i (win_q[0][1]),
    .p02_i (win_q[0][2]),
    .p10_i (win_q[1][0]),
    .p11_i (win_q[1][1]),
    .p12_i (win_q[1][2]),
    .p20_i (win_q[2][0]),
    .p21_i (win_q[2][1]),
    .p22_i (win_q[2][2]),
    .mag_o (mag_s)
  );

  assign de_o    = de_q[LATENCY-1];
  assign vsync_o = vs_q[LATENCY-1];
  assign data_o  = data_q;
endmodule
